// File: rtl/nes_gamepad.sv
// nes_gamepad: memory-mapped NES-style pad poller for the PicoSoC iomem bus.
// It serially scans the pad's shift register using latch, clock and data lines.
// It also keeps the last scanned button state, sticky newly-pressed flags and a
// count of completed scans. Polls start either from a free-running timer (AUTO)
// or from a one-shot POLL_NOW write.
module nes_gamepad #(
    parameter int CLK_DIV     = 96,      // clk cycles per pad tick, >= 2
    parameter int POLL_CYCLES = 266667   // clk cycles between automatic polls
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic        iomem_ready,
    output logic [31:0] iomem_rdata,
    output logic        pad_latch,
    output logic        pad_clk,
    input  logic        pad_data
);

    localparam int TICK_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int POLL_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(CLK_DIV - 1);
    localparam logic [POLL_W-1:0] POLL_MAX = POLL_W'(POLL_CYCLES - 1);

    localparam logic [1:0] REG_BUTTONS = 2'd0;
    localparam logic [1:0] REG_EDGES   = 2'd1;
    localparam logic [1:0] REG_CTRL    = 2'd2;
    localparam logic [1:0] REG_FRAMES  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_GAP,
        S_CLK_LO,
        S_CLK_HI,
        S_DONE
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e              state_q, state_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic                latch_ph_q, latch_ph_d;   // which of the two latch ticks
    logic [2:0]          bit_q, bit_d;
    logic [7:0]          shift_q, shift_d;
    logic [7:0]          buttons_q, buttons_d;
    logic [7:0]          edges_q, edges_d;
    logic [15:0]         frames_q, frames_d;
    logic                auto_q, auto_d;
    logic [POLL_W-1:0]   poll_q, poll_d;
    logic                ready_q, ready_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                pad_latch_q, pad_clk_q;
    logic                pad_data_q;

    // ------------------------------------------------------------------
    // Bus decode and trigger sources
    // ------------------------------------------------------------------
    logic        bus_acc, bus_wr, bus_rd;
    logic [1:0]  reg_sel;
    logic [7:0]  w1c_mask;
    logic        manual_trig, auto_trig, trigger, tick;

    // Address bits outside [3:2] and the upper write-data bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = &{1'b0, iomem_addr[31:4], iomem_addr[1:0], iomem_wdata[31:8]};

    assign tick = (tick_q == TICK_MAX);

    // Decode the accepted transfer; a transfer is accepted in the cycle before ready.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, otherwise paths that skip an assignment infer a latch.
        reg_sel     = iomem_addr[3:2];
        bus_acc     = iomem_valid && !ready_q;
        bus_wr      = bus_acc && (iomem_wstrb != 4'b0000);
        bus_rd      = bus_acc && (iomem_wstrb == 4'b0000);
        w1c_mask    = 8'h00;
        manual_trig = 1'b0;
        auto_d      = auto_q;
        if (bus_wr && reg_sel == REG_EDGES) begin
            w1c_mask = iomem_wdata[7:0];
        end
        if (bus_wr && reg_sel == REG_CTRL) begin
            auto_d      = iomem_wdata[0];
            manual_trig = iomem_wdata[1];
        end
        auto_trig = auto_q && (poll_q == POLL_MAX);
        trigger   = manual_trig || auto_trig;
    end

    // Read mux and one-shot ready; rdata is zero whenever ready is not asserted.
    always_comb begin
        ready_d = iomem_valid && !ready_q;
        rdata_d = 32'h0;
        if (bus_rd) begin
            case (reg_sel)
                REG_BUTTONS: rdata_d = {24'h0, buttons_q};
                REG_EDGES:   rdata_d = {24'h0, edges_q};
                REG_CTRL:    rdata_d = {31'h0, auto_q};
                default:     rdata_d = {16'h0, frames_q};
            endcase
        end
    end

    // Free-running poll timer, held at zero while AUTO is off.
    always_comb begin
        poll_d = '0;
        if (auto_q && poll_q != POLL_MAX) begin
            poll_d = poll_q + POLL_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Scan FSM: next state, tick counter and shift/result registers
    // ------------------------------------------------------------------
    // Sequence the pad scan and commit results in the single DONE cycle.
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        latch_ph_d = latch_ph_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        buttons_d  = buttons_q;
        edges_d    = edges_q & ~w1c_mask;
        frames_d   = frames_q;

        if (state_q != S_IDLE) begin
            tick_d = tick ? '0 : tick_q + TICK_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                tick_d = '0;
                if (trigger) begin
                    state_d    = S_LATCH;
                    latch_ph_d = 1'b0;
                end
            end
            S_LATCH: begin
                if (tick) begin
                    if (latch_ph_q) begin
                        state_d = S_GAP;
                    end else begin
                        latch_ph_d = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (tick) begin
                    shift_d[0] = ~pad_data_q;
                    bit_d      = 3'd1;
                    state_d    = S_CLK_LO;
                end
            end
            S_CLK_LO: begin
                if (tick) begin
                    state_d = S_CLK_HI;
                end
            end
            S_CLK_HI: begin
                if (tick) begin
                    shift_d[bit_q] = ~pad_data_q;
                    if (bit_q == 3'd7) begin
                        state_d = S_DONE;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        state_d = S_CLK_LO;
                    end
                end
            end
            S_DONE: begin
                // A fresh press beats a W1C clear of the same bit in this cycle.
                buttons_d = shift_q;
                edges_d   = (edges_q & ~w1c_mask) | (shift_q & ~buttons_q);
                frames_d  = frames_q + 16'd1;
                tick_d    = '0;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Scan state and results; reset drops any partial scan on the spot.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q    <= S_IDLE;
            tick_q     <= '0;
            latch_ph_q <= 1'b0;
            bit_q      <= 3'd0;
            shift_q    <= 8'h00;
            buttons_q  <= 8'h00;
            edges_q    <= 8'h00;
            frames_q   <= 16'h0000;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            latch_ph_q <= latch_ph_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            buttons_q  <= buttons_d;
            edges_q    <= edges_d;
            frames_q   <= frames_d;
        end
    end

    // Control register, poll timer and bus response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            auto_q  <= 1'b0;
            poll_q  <= '0;
            ready_q <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            auto_q  <= auto_d;
            poll_q  <= poll_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
        end
    end

    // Pad-side registers: strobes follow the next state so they are glitch-free
    // and aligned with it; data is registered once, which is safe because it is
    // only used a full tick after the pad last changed it.
    always_ff @(posedge clk) begin
        if (reset) begin
            pad_latch_q <= 1'b0;
            pad_clk_q   <= 1'b1;
            pad_data_q  <= 1'b1;
        end else begin
            pad_latch_q <= (state_d == S_LATCH);
            pad_clk_q   <= (state_d != S_CLK_LO);
            pad_data_q  <= pad_data;
        end
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign pad_latch   = pad_latch_q;
    assign pad_clk     = pad_clk_q;

endmodule
